// File: rtl/brent_kung_adder_if.sv
// Operand/result bundle for the 8-bit Brent-Kung adder; bit 1 is the LSB.
interface brent_kung_adder_if;
  logic A_1, A_2, A_3, A_4, A_5, A_6, A_7, A_8;
  logic B_1, B_2, B_3, B_4, B_5, B_6, B_7, B_8;
  logic C_0;
  logic S_1, S_2, S_3, S_4, S_5, S_6, S_7, S_8;
  logic C_out;

  modport master (
    output A_1, A_2, A_3, A_4, A_5, A_6, A_7, A_8,
    output B_1, B_2, B_3, B_4, B_5, B_6, B_7, B_8,
    output C_0,
    input  S_1, S_2, S_3, S_4, S_5, S_6, S_7, S_8,
    input  C_out
  );

  modport slave (
    input  A_1, A_2, A_3, A_4, A_5, A_6, A_7, A_8,
    input  B_1, B_2, B_3, B_4, B_5, B_6, B_7, B_8,
    input  C_0,
    output S_1, S_2, S_3, S_4, S_5, S_6, S_7, S_8,
    output C_out
  );
endinterface

// File: rtl/brent_kung_adder.sv
// 8-bit Brent-Kung parallel-prefix adder with carry-in/out and a registered 9-bit result.
module brent_kung_adder (
  input  logic                 clk,
  input  logic                 rst_n,
  brent_kung_adder_if.slave    bus
);

  logic [8:1] w_a;
  logic [8:1] w_b;
  logic [8:1] w_g;
  logic [8:1] w_p;
  logic       w_c0;

  assign w_a  = {bus.A_8, bus.A_7, bus.A_6, bus.A_5, bus.A_4, bus.A_3, bus.A_2, bus.A_1};
  assign w_b  = {bus.B_8, bus.B_7, bus.B_6, bus.B_5, bus.B_4, bus.B_3, bus.B_2, bus.B_1};
  assign w_c0 = bus.C_0;

  assign w_g = w_a & w_b;
  assign w_p = w_a ^ w_b;

  // Up-sweep level 1: adjacent pairs
  logic w_g21, w_p21, w_g43, w_p43, w_g65, w_p65, w_g87, w_p87;
  assign w_g21 = w_g[2] | (w_p[2] & w_g[1]);
  assign w_p21 = w_p[2] & w_p[1];
  assign w_g43 = w_g[4] | (w_p[4] & w_g[3]);
  assign w_p43 = w_p[4] & w_p[3];
  assign w_g65 = w_g[6] | (w_p[6] & w_g[5]);
  assign w_p65 = w_p[6] & w_p[5];
  assign w_g87 = w_g[8] | (w_p[8] & w_g[7]);
  assign w_p87 = w_p[8] & w_p[7];

  // Up-sweep level 2
  logic w_g41, w_p41, w_g85, w_p85;
  assign w_g41 = w_g43 | (w_p43 & w_g21);
  assign w_p41 = w_p43 & w_p21;
  assign w_g85 = w_g87 | (w_p87 & w_g65);
  assign w_p85 = w_p87 & w_p65;

  // Up-sweep level 3
  logic w_g81, w_p81;
  assign w_g81 = w_g85 | (w_p85 & w_g41);
  assign w_p81 = w_p85 & w_p41;

  // Down-sweep fills the remaining odd and [6:1] spans
  logic w_g61, w_p61, w_g31, w_p31, w_g51, w_p51, w_g71, w_p71;
  assign w_g61 = w_g65 | (w_p65 & w_g41);
  assign w_p61 = w_p65 & w_p41;
  assign w_g31 = w_g[3] | (w_p[3] & w_g21);
  assign w_p31 = w_p[3] & w_p21;
  assign w_g51 = w_g[5] | (w_p[5] & w_g41);
  assign w_p51 = w_p[5] & w_p41;
  assign w_g71 = w_g[7] | (w_p[7] & w_g61);
  assign w_p71 = w_p[7] & w_p61;

  // Fold the carry-in into each group span
  logic [8:0] w_c;
  assign w_c[0] = w_c0;
  assign w_c[1] = w_g[1] | (w_p[1] & w_c0);
  assign w_c[2] = w_g21  | (w_p21  & w_c0);
  assign w_c[3] = w_g31  | (w_p31  & w_c0);
  assign w_c[4] = w_g41  | (w_p41  & w_c0);
  assign w_c[5] = w_g51  | (w_p51  & w_c0);
  assign w_c[6] = w_g61  | (w_p61  & w_c0);
  assign w_c[7] = w_g71  | (w_p71  & w_c0);
  assign w_c[8] = w_g81  | (w_p81  & w_c0);

  logic [8:1] w_sum;
  assign w_sum = w_p ^ w_c[7:0];

  logic [8:1] r_sum;
  logic       r_cout;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
    end else begin
      r_sum  <= w_sum;
      r_cout <= w_c[8];
    end
  end

  assign bus.S_1   = r_sum[1];
  assign bus.S_2   = r_sum[2];
  assign bus.S_3   = r_sum[3];
  assign bus.S_4   = r_sum[4];
  assign bus.S_5   = r_sum[5];
  assign bus.S_6   = r_sum[6];
  assign bus.S_7   = r_sum[7];
  assign bus.S_8   = r_sum[8];
  assign bus.C_out = r_cout;

endmodule

// File: tb/tb_brent_kung_adder.sv
// Self-checking bench: directed vector table, reset checks, random stream with mid-stream reset.
module tb_brent_kung_adder;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  brent_kung_adder_if bus ();

  brent_kung_adder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       cout;
    string      name;
  } vec_t;

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic c);
    {bus.A_8, bus.A_7, bus.A_6, bus.A_5, bus.A_4, bus.A_3, bus.A_2, bus.A_1} = a;
    {bus.B_8, bus.B_7, bus.B_6, bus.B_5, bus.B_4, bus.B_3, bus.B_2, bus.B_1} = b;
    bus.C_0 = c;
  endtask

  function automatic logic [7:0] dut_sum();
    return {bus.S_8, bus.S_7, bus.S_6, bus.S_5, bus.S_4, bus.S_3, bus.S_2, bus.S_1};
  endfunction

  task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%03h expected=0x%03h", name, got, exp);
    end
  endtask

  // Drive on the falling edge, sample 1 time unit after the next rising edge
  task automatic step(input logic [7:0] a, input logic [7:0] b, input logic c, input logic rn);
    @(negedge clk);
    drive(a, b, c);
    rst_n = rn;
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[6];

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rc;
    logic       rrn;
    logic [8:0] golden;

    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    drive(8'hFF, 8'hFF, 1'b1);

    tbl[0] = '{a: 8'd3,   b: 8'd1,   cin: 1'b0, s: 8'd4,   cout: 1'b0, name: "a3_b1"};
    tbl[1] = '{a: 8'd133, b: 8'd140, cin: 1'b0, s: 8'd17,  cout: 1'b1, name: "a133_b140"};
    tbl[2] = '{a: 8'd255, b: 8'd0,   cin: 1'b1, s: 8'd0,   cout: 1'b1, name: "ripple_cin"};
    tbl[3] = '{a: 8'd255, b: 8'd255, cin: 1'b1, s: 8'd255, cout: 1'b1, name: "max_all"};
    tbl[4] = '{a: 8'd0,   b: 8'd0,   cin: 1'b0, s: 8'd0,   cout: 1'b0, name: "zero"};
    tbl[5] = '{a: 8'h0F,  b: 8'hF1,  cin: 1'b0, s: 8'h00,  cout: 1'b1, name: "mid_carry"};

    // Two reset cycles with non-zero inputs applied
    step(8'hFF, 8'hFF, 1'b1, 1'b0);
    check("reset_cycle1", {bus.C_out, dut_sum()}, 9'd0);
    step(8'hAA, 8'h55, 1'b1, 1'b0);
    check("reset_cycle2", {bus.C_out, dut_sum()}, 9'd0);

    for (int i = 0; i < 6; i++) begin
      step(tbl[i].a, tbl[i].b, tbl[i].cin, 1'b1);
      check({tbl[i].name, "_sum"}, {1'b0, dut_sum()}, {1'b0, tbl[i].s});
      check({tbl[i].name, "_cout"}, {8'd0, bus.C_out}, {8'd0, tbl[i].cout});
    end

    // Reset must win over live operands, then normal operation resumes next cycle
    step(8'd200, 8'd100, 1'b1, 1'b0);
    check("reset_wins", {bus.C_out, dut_sum()}, 9'd0);
    step(8'd200, 8'd100, 1'b1, 1'b1);
    check("after_reset", {bus.C_out, dut_sum()}, 9'd301);

    // Random back-to-back stream with reset pulled low mid-stream
    for (int i = 0; i < 300; i++) begin
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      rc  = 1'($urandom);
      rrn = (i == 150 || i == 151 || i == 220) ? 1'b0 : 1'b1;
      golden = rrn ? (9'(ra) + 9'(rb) + 9'(rc)) : 9'd0;
      step(ra, rb, rc, rrn);
      check("random", {bus.C_out, dut_sum()}, golden);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
